// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the icache/dcache controllers, the arbiter and memory.
// slave: the arbiter's view. master: the environment's view (caches + memory).
// Optional macro ARB_PERF_EN adds the performance counter outputs.
interface mem_bus_arbiter_if #(parameter int XLEN = 32);
    logic [1:0]        proc2Imem_command;
    logic [XLEN-1:0]   proc2Imem_addr;
    logic [1:0]        proc2Dmem_command;
    logic [XLEN-1:0]   proc2Dmem_addr;
    logic [2*XLEN-1:0] proc2Dmem_data;
    logic [3:0]        mem2proc_response;
    logic [2*XLEN-1:0] mem2proc_data;
    logic [3:0]        mem2proc_tag;
    logic [1:0]        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [2*XLEN-1:0] proc2mem_data;
    logic [3:0]        Imem2proc_response;
    logic [2*XLEN-1:0] Imem2proc_data;
    logic [3:0]        Imem2proc_tag;
    logic [3:0]        Dmem2proc_response;
    logic [2*XLEN-1:0] Dmem2proc_data;
    logic [3:0]        Dmem2proc_tag;
    logic              dcache_request;
`ifdef ARB_PERF_EN
    logic [31:0]       perf_icache_grants;
    logic [31:0]       perf_dcache_grants;
    logic [31:0]       perf_conflicts;
    logic [31:0]       perf_dropped_tags;
`endif

    modport slave (
        input  proc2Imem_command, proc2Imem_addr,
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        output dcache_request
`ifdef ARB_PERF_EN
        , output perf_icache_grants, perf_dcache_grants, perf_conflicts, perf_dropped_tags
`endif
    );

    modport master (
        output proc2Imem_command, proc2Imem_addr,
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        input  dcache_request
`ifdef ARB_PERF_EN
        , input perf_icache_grants, perf_dcache_grants, perf_conflicts, perf_dropped_tags
`endif
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates icache and dcache onto one memory bus. Dcache has priority
// except when the icache has been blocked STARVE_LIMIT cycles in a row.
// A tag owner table steers returning load data to the requester that
// issued the load; returns with no live owner are dropped.
// Optional macro ARB_PERF_EN adds 32-bit saturating perf counters.
module mem_bus_arbiter #(
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam int         SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [NUM_TAGS-1:0] valid;
    logic [NUM_TAGS-1:0] owner;     // 0 = icache, 1 = dcache
    logic [SW-1:0]       starve_cnt;

    logic i_req, d_req, i_win, d_win, alloc, ret_hit, ret_drop;
    logic [1:0] win_cmd;

    // Grant decision and accept/return classification.
    always_comb begin
        i_req    = bus.proc2Imem_command != BUS_NONE;
        d_req    = bus.proc2Dmem_command != BUS_NONE;
        i_win    = i_req && (!d_req || starve_cnt == STARVE_MAX);
        d_win    = d_req && !i_win;
        win_cmd  = d_win ? bus.proc2Dmem_command :
                   i_win ? bus.proc2Imem_command : BUS_NONE;
        alloc    = win_cmd == BUS_LOAD && bus.mem2proc_response != 4'd0;
        ret_hit  = bus.mem2proc_tag != 4'd0 && valid[bus.mem2proc_tag];
        ret_drop = bus.mem2proc_tag != 4'd0 && !valid[bus.mem2proc_tag];
    end

    // Bus drive and response/return steering; everything held quiet in reset.
    always_comb begin
        bus.proc2mem_command   = BUS_NONE;
        bus.proc2mem_addr      = '0;
        bus.proc2mem_data      = '0;
        bus.Imem2proc_response = 4'd0;
        bus.Dmem2proc_response = 4'd0;
        bus.Imem2proc_tag      = 4'd0;
        bus.Imem2proc_data     = '0;
        bus.Dmem2proc_tag      = 4'd0;
        bus.Dmem2proc_data     = '0;
        bus.dcache_request     = 1'b0;
        if (!reset) begin
            if (d_win) begin
                bus.proc2mem_command   = bus.proc2Dmem_command;
                bus.proc2mem_addr      = bus.proc2Dmem_addr;
                bus.proc2mem_data      = bus.proc2Dmem_data;
                bus.Dmem2proc_response = bus.mem2proc_response;
                bus.dcache_request     = 1'b1;
            end else if (i_win) begin
                bus.proc2mem_command   = bus.proc2Imem_command;
                bus.proc2mem_addr      = bus.proc2Imem_addr;
                bus.Imem2proc_response = bus.mem2proc_response;
            end
            if (ret_hit) begin
                if (owner[bus.mem2proc_tag]) begin
                    bus.Dmem2proc_tag  = bus.mem2proc_tag;
                    bus.Dmem2proc_data = bus.mem2proc_data;
                end else begin
                    bus.Imem2proc_tag  = bus.mem2proc_tag;
                    bus.Imem2proc_data = bus.mem2proc_data;
                end
            end
        end
    end

    // Owner table and starvation counter; allocation is applied after the
    // clear so a same-cycle reuse of a returning tag keeps the new owner.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid      <= '0;
            owner      <= '0;
            starve_cnt <= '0;
        end else begin
            if (ret_hit)
                valid[bus.mem2proc_tag] <= 1'b0;
            if (alloc) begin
                valid[bus.mem2proc_response] <= 1'b1;
                owner[bus.mem2proc_response] <= d_win;
            end
            if (i_req && !i_win)
                starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
        end
    end

`ifdef ARB_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.perf_icache_grants <= '0;
            bus.perf_dcache_grants <= '0;
            bus.perf_conflicts     <= '0;
            bus.perf_dropped_tags  <= '0;
        end else begin
            if (i_win && alloc && bus.perf_icache_grants != '1)
                bus.perf_icache_grants <= bus.perf_icache_grants + 1'b1;
            if (d_win && bus.mem2proc_response != 4'd0 && bus.perf_dcache_grants != '1)
                bus.perf_dcache_grants <= bus.perf_dcache_grants + 1'b1;
            if (i_req && d_req && bus.perf_conflicts != '1)
                bus.perf_conflicts <= bus.perf_conflicts + 1'b1;
            if (ret_drop && bus.perf_dropped_tags != '1)
                bus.perf_dropped_tags <= bus.perf_dropped_tags + 1'b1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = ret_drop;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: each accepted request pushes the
// expected destination of its future return; returns pop and compare.
module tb_mem_bus_arbiter;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] TO_I = 2'd0, TO_D = 2'd1, TO_NONE = 2'd2;

    typedef struct packed {
        logic [3:0]  tag;
        logic [1:0]  dest;
        logic [63:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    mem_bus_arbiter_if #(.XLEN(32)) bus();
    mem_bus_arbiter #(.NUM_TAGS(16), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.proc2Imem_command = BUS_NONE;
        bus.proc2Imem_addr    = '0;
        bus.proc2Dmem_command = BUS_NONE;
        bus.proc2Dmem_addr    = '0;
        bus.proc2Dmem_data    = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic push(input logic [3:0] t, input logic [1:0] d, input logic [63:0] data);
        exp_t e;
        e.tag = t; e.dest = d; e.data = data;
        exp_q.push_back(e);
    endtask

    // Compare current return outputs against the scoreboard entry for tag t.
    task automatic check_ret(input logic [3:0] t);
        exp_t e;
        int   idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].tag == t) idx = i;
        chk("sb_found", 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
            e = exp_q[idx];
            exp_q.delete(idx);
            chk("ret_itag",  64'(bus.Imem2proc_tag),  (e.dest == TO_I) ? 64'(t) : 64'd0);
            chk("ret_idata", bus.Imem2proc_data,      (e.dest == TO_I) ? e.data : 64'd0);
            chk("ret_dtag",  64'(bus.Dmem2proc_tag),  (e.dest == TO_D) ? 64'(t) : 64'd0);
            chk("ret_ddata", bus.Dmem2proc_data,      (e.dest == TO_D) ? e.data : 64'd0);
        end
    endtask

    task automatic ret(input logic [3:0] t, input logic [63:0] data);
        bus.mem2proc_tag  = t;
        bus.mem2proc_data = data;
        #1;
        check_ret(t);
        next();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        // Requests during reset must not reach the bus or the caches.
        bus.proc2Imem_command = BUS_LOAD;
        bus.proc2Imem_addr    = 32'h40;
        bus.mem2proc_response = 4'd1;
        bus.mem2proc_tag      = 4'd1;
        #1;
        chk("rst_cmd",   64'(bus.proc2mem_command), 64'd0);
        chk("rst_addr",  64'(bus.proc2mem_addr), 64'd0);
        chk("rst_iresp", 64'(bus.Imem2proc_response), 64'd0);
        chk("rst_itag",  64'(bus.Imem2proc_tag), 64'd0);
        next();
        reset = 1'b0;

        // Icache-only load, accepted with tag 3, returns 5 cycles later.
        bus.proc2Imem_command = BUS_LOAD;
        bus.proc2Imem_addr    = 32'h100;
        bus.mem2proc_response = 4'd3;
        #1;
        chk("t1_iresp", 64'(bus.Imem2proc_response), 64'd3);
        chk("t1_dresp", 64'(bus.Dmem2proc_response), 64'd0);
        chk("t1_cmd",   64'(bus.proc2mem_command), 64'(BUS_LOAD));
        chk("t1_addr",  64'(bus.proc2mem_addr), 64'h100);
        chk("t1_data",  bus.proc2mem_data, 64'd0);
        chk("t1_dreq",  64'(bus.dcache_request), 64'd0);
        push(4'd3, TO_I, 64'hDEAD_BEEF_0000_0001);
        next();
        repeat (4) next();
        ret(4'd3, 64'hDEAD_BEEF_0000_0001);

        // Both request together: dcache wins.
        bus.proc2Imem_command = BUS_LOAD;
        bus.proc2Imem_addr    = 32'h200;
        bus.proc2Dmem_command = BUS_LOAD;
        bus.proc2Dmem_addr    = 32'h300;
        bus.mem2proc_response = 4'd5;
        #1;
        chk("t2_dresp", 64'(bus.Dmem2proc_response), 64'd5);
        chk("t2_iresp", 64'(bus.Imem2proc_response), 64'd0);
        chk("t2_dreq",  64'(bus.dcache_request), 64'd1);
        chk("t2_addr",  64'(bus.proc2mem_addr), 64'h300);
        push(4'd5, TO_D, 64'h5555_0000_AAAA_0005);
        next();
        ret(4'd5, 64'h5555_0000_AAAA_0005);

        // Continuous contention: icache wins on the 5th cycle, then counter restarts.
        for (int c = 0; c < 6; c++) begin
            bus.proc2Imem_command = BUS_LOAD;
            bus.proc2Imem_addr    = 32'h500;
            bus.proc2Dmem_command = BUS_LOAD;
            bus.proc2Dmem_addr    = 32'h600;
            #1;
            chk("t3_dreq", 64'(bus.dcache_request), (c != 4) ? 64'd1 : 64'd0);
            chk("t3_addr", 64'(bus.proc2mem_addr), (c != 4) ? 64'h600 : 64'h500);
            next();
        end

        // Out-of-order returns: icache tag 7, dcache tag 9; memory returns 9 then 7.
        bus.proc2Imem_command = BUS_LOAD;
        bus.proc2Imem_addr    = 32'h700;
        bus.mem2proc_response = 4'd7;
        #1;
        chk("t4_iresp", 64'(bus.Imem2proc_response), 64'd7);
        push(4'd7, TO_I, 64'h7777_7777_0000_0007);
        next();
        bus.proc2Dmem_command = BUS_LOAD;
        bus.proc2Dmem_addr    = 32'h900;
        bus.mem2proc_response = 4'd9;
        #1;
        chk("t4_dresp", 64'(bus.Dmem2proc_response), 64'd9);
        push(4'd9, TO_D, 64'h9999_9999_0000_0009);
        next();
        next();
        ret(4'd9, 64'h9999_9999_0000_0009);
        ret(4'd7, 64'h7777_7777_0000_0007);

        // Store accepted with tag 2 allocates nothing; a later tag 2 is dropped.
        bus.proc2Dmem_command = BUS_STORE;
        bus.proc2Dmem_addr    = 32'h220;
        bus.proc2Dmem_data    = 64'h0123_4567_89AB_CDEF;
        bus.mem2proc_response = 4'd2;
        #1;
        chk("t5_sdata", bus.proc2mem_data, 64'h0123_4567_89AB_CDEF);
        chk("t5_scmd",  64'(bus.proc2mem_command), 64'(BUS_STORE));
        chk("t5_dresp", 64'(bus.Dmem2proc_response), 64'd2);
        push(4'd2, TO_NONE, 64'h0);
        next();
        ret(4'd2, 64'hFFFF_0000_FFFF_0002);

        // Tag 0 on the return path is never routed.
        bus.mem2proc_tag  = 4'd0;
        bus.mem2proc_data = 64'h1234;
        #1;
        chk("t0_itag",  64'(bus.Imem2proc_tag), 64'd0);
        chk("t0_idata", bus.Imem2proc_data, 64'd0);
        chk("t0_ddata", bus.Dmem2proc_data, 64'd0);
        next();

        // Same-cycle clear and re-allocation of tag 6: old owner gets the data,
        // new owner holds the entry afterwards.
        bus.proc2Dmem_command = BUS_LOAD;
        bus.proc2Dmem_addr    = 32'h660;
        bus.mem2proc_response = 4'd6;
        #1;
        push(4'd6, TO_D, 64'hD6D6_D6D6_D6D6_D6D6);
        next();
        bus.proc2Imem_command = BUS_LOAD;
        bus.proc2Imem_addr    = 32'h661;
        bus.mem2proc_response = 4'd6;
        bus.mem2proc_tag      = 4'd6;
        bus.mem2proc_data     = 64'hD6D6_D6D6_D6D6_D6D6;
        #1;
        chk("t7_iresp", 64'(bus.Imem2proc_response), 64'd6);
        check_ret(4'd6);
        push(4'd6, TO_I, 64'h1616_1616_1616_1616);
        next();
        ret(4'd6, 64'h1616_1616_1616_1616);

        // Reset mid-transaction discards ownership.
        bus.proc2Imem_command = BUS_LOAD;
        bus.proc2Imem_addr    = 32'h440;
        bus.mem2proc_response = 4'd4;
        #1;
        chk("t6_iresp", 64'(bus.Imem2proc_response), 64'd4);
        push(4'd4, TO_NONE, 64'h0);
        next();
        reset = 1'b1;
        bus.proc2Imem_command = BUS_LOAD;
        bus.proc2Imem_addr    = 32'h880;
        bus.mem2proc_response = 4'd8;
        #1;
        chk("t6_rcmd",  64'(bus.proc2mem_command), 64'd0);
        chk("t6_riresp", 64'(bus.Imem2proc_response), 64'd0);
        push(4'd8, TO_NONE, 64'h0);
        next();
        reset = 1'b0;
        ret(4'd4, 64'h4444_4444_4444_4444);
        ret(4'd8, 64'h8888_8888_8888_8888);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
